// File: rtl/traffic_phase_scheduler.sv
// Actuated two-phase intersection scheduler: detector-driven min/max green, yellow and all-red clearance, emergency preemption.
// Latency: state, timer and pend flags register on clk; lamps and phase decode combinationally from the current state.
// Backpressure: none; detector and preempt inputs are levels sampled every cycle.
module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int TW        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       det_a,
  input  logic       det_b,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [1:0] TL1,
  output logic [1:0] TL2,
  output logic [1:0] TL3,
  output logic [1:0] TL4,
  output logic [2:0] phase,
  output logic       pend_a,
  output logic       pend_b
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5
  } state_t;

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_GRN = 2'b01;
  localparam logic [1:0] LAMP_YEL = 2'b10;

  // Thresholds are "last cycle" values since the timer starts at 0 on entry.
  localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_YEL = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR  = TW'(ALLRED_T - 1);

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          in_green;
  logic          enter_a;
  logic          enter_b;

  assign in_green = (state == A_GRN) || (state == B_GRN);
  assign enter_a  = (state_nxt == A_GRN) && (state != A_GRN);
  assign enter_b  = (state_nxt == B_GRN) && (state != B_GRN);

  // Next-state: preemption overrides green timing but never shortens clearance.
  always_comb begin
    state_nxt = state;
    case (state)
      A_GRN: begin
        if (emg_req) begin
          if (emg_dir) state_nxt = A_YEL;
        end else if (pend_b && (timer >= T_MIN) && (!det_a || (timer >= T_MAX))) begin
          state_nxt = A_YEL;
        end
      end
      A_YEL: if (timer >= T_YEL) state_nxt = AR_AB;
      AR_AB: if (timer >= T_AR) state_nxt = (emg_req && !emg_dir) ? A_GRN : B_GRN;
      B_GRN: begin
        if (emg_req) begin
          if (!emg_dir) state_nxt = B_YEL;
        end else if (pend_a && (timer >= T_MIN) && (!det_b || (timer >= T_MAX))) begin
          state_nxt = B_YEL;
        end
      end
      B_YEL: if (timer >= T_YEL) state_nxt = AR_BA;
      AR_BA: if (timer >= T_AR) state_nxt = (emg_req && emg_dir) ? B_GRN : A_GRN;
      default: state_nxt = AR_BA;
    endcase
  end

  // State register plus interval timer; green timer saturates so a resting green never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= A_GRN;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)            timer <= '0;
      else if (in_green && timer == T_MAX) timer <= timer;
      else                               timer <= timer + TW'(1);
    end
  end

  // Service requests latch while the phase is not green and drop as it is granted (grant wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      if (enter_a)                         pend_a <= 1'b0;
      else if (det_a && state != A_GRN)    pend_a <= 1'b1;
      if (enter_b)                         pend_b <= 1'b0;
      else if (det_b && state != B_GRN)    pend_b <= 1'b1;
    end
  end

  // Lamp decode: every unlisted state is all-red.
  always_comb begin
    TL1   = LAMP_RED;
    TL2   = LAMP_RED;
    TL3   = LAMP_RED;
    TL4   = LAMP_RED;
    phase = state;
    case (state)
      A_GRN: begin TL1 = LAMP_GRN; TL3 = LAMP_GRN; end
      A_YEL: begin TL1 = LAMP_YEL; TL3 = LAMP_YEL; end
      B_GRN: begin TL2 = LAMP_GRN; TL4 = LAMP_GRN; end
      B_YEL: begin TL2 = LAMP_YEL; TL4 = LAMP_YEL; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios then randomized traffic.
// Latency: outputs compared on the falling edge against a phase/stage/elapsed-count model.
// Backpressure: none.
module tb_traffic_phase_scheduler;

  localparam int MIN_GREEN = 5;
  localparam int MAX_GREEN = 20;
  localparam int YELLOW_T  = 3;
  localparam int ALLRED_T  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       det_a, det_b, emg_req, emg_dir;
  logic [1:0] TL1, TL2, TL3, TL4;
  logic [2:0] phase;
  logic       pend_a, pend_b;

  int checks = 0;
  int errors = 0;

  // Reference model: which direction owns the right of way, which stage, cycles spent in it.
  int m_dir;    // 0 = A, 1 = B
  int m_stage;  // 0 green, 1 yellow, 2 all-red
  int m_cnt;
  bit m_pa, m_pb;

  traffic_phase_scheduler dut (
    .clk(clk), .rst(rst), .det_a(det_a), .det_b(det_b),
    .emg_req(emg_req), .emg_dir(emg_dir),
    .TL1(TL1), .TL2(TL2), .TL3(TL3), .TL4(TL4),
    .phase(phase), .pend_a(pend_a), .pend_b(pend_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_dir = 0; m_stage = 0; m_cnt = 0; m_pa = 0; m_pb = 0;
  endfunction

  task automatic model_step(input bit da, input bit db, input bit er, input bit ed);
    int  nd, ns, nc;
    bit  was_ga, was_gb, now_ga, now_gb, other_p, own_d, leave;
    nd = m_dir; ns = m_stage; nc = m_cnt + 1;
    if (m_stage == 0) begin
      other_p = (m_dir == 0) ? m_pb : m_pa;
      own_d   = (m_dir == 0) ? da : db;
      if (er) leave = (int'(ed) != m_dir);
      else    leave = other_p && (m_cnt >= MIN_GREEN - 1) && (!own_d || m_cnt >= MAX_GREEN - 1);
      if (leave) begin ns = 1; nc = 0; end
    end else if (m_stage == 1) begin
      if (m_cnt + 1 >= YELLOW_T) begin ns = 2; nc = 0; end
    end else begin
      if (m_cnt + 1 >= ALLRED_T) begin
        ns = 0; nc = 0;
        nd = er ? int'(ed) : 1 - m_dir;
      end
    end
    was_ga = (m_stage == 0 && m_dir == 0);
    was_gb = (m_stage == 0 && m_dir == 1);
    now_ga = (ns == 0 && nd == 0);
    now_gb = (ns == 0 && nd == 1);
    if (now_ga && !was_ga)  m_pa = 0;
    else if (da && !was_ga) m_pa = 1;
    if (now_gb && !was_gb)  m_pb = 0;
    else if (db && !was_gb) m_pb = 1;
    m_dir = nd; m_stage = ns; m_cnt = nc;
  endtask

  task automatic check_all();
    logic [1:0] lamp, la, lb;
    lamp = (m_stage == 0) ? 2'b01 : (m_stage == 1) ? 2'b10 : 2'b00;
    la = (m_dir == 0) ? lamp : 2'b00;
    lb = (m_dir == 1) ? lamp : 2'b00;
    chk("tl1", 8'(TL1), 8'(la));
    chk("tl3", 8'(TL3), 8'(la));
    chk("tl2", 8'(TL2), 8'(lb));
    chk("tl4", 8'(TL4), 8'(lb));
    chk("phase", 8'(phase), 8'(m_dir * 3 + m_stage));
    chk("pend_a", 8'(pend_a), 8'(m_pa));
    chk("pend_b", 8'(pend_b), 8'(m_pb));
  endtask

  // One clock: drive at the falling edge, model on the rising edge, compare on the next falling edge.
  task automatic cyc(input bit da, input bit db, input bit er, input bit ed);
    det_a = da; det_b = db; emg_req = er; emg_dir = ed;
    @(posedge clk);
    model_step(da, db, er, ed);
    @(negedge clk);
    check_all();
  endtask

  // Lamp safety on every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("safety", 8'(((TL1 | TL3) != 2'b00) && ((TL2 | TL4) != 2'b00)), 8'd0);
      chk("lamp_code", 8'((TL1 == 2'b11) || (TL2 == 2'b11) || (TL3 == 2'b11) || (TL4 == 2'b11)), 8'd0);
    end
  end

  task automatic run_test1();
    int exp_seq [10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i == 1), 1'b0, 1'b0);
      chk("t1_seq", 8'(phase), 8'(exp_seq[i]));
    end
    chk("t1_tl2", 8'(TL2), 8'd1);
    chk("t1_pendb", 8'(pend_b), 8'd0);
  endtask

  task automatic goto_phase0(input bit da);
    int n = 0;
    while (phase !== 3'd0 && n < 40) begin
      cyc(da && (n == 0), 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_a_grn", 8'(phase), 8'd0);
  endtask

  initial begin
    int cnt;
    int burst;
    bit er, ed;
    rst = 1'b1; det_a = 0; det_b = 0; emg_req = 0; emg_dir = 0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_phase", 8'(phase), 8'd0);
    chk("rst_tl1", 8'(TL1), 8'd1);
    rst = 1'b0;

    // Test 1: min-green then clearance into B.
    run_test1();

    // Test 4: preempt toward A from early B green.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("t4_byel", 8'(phase), 8'd4);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
    chk("t4_agrn", 8'(phase), 8'd0);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 1, 0);
      chk("t4_hold", 8'(phase), 8'd0);
    end
    chk("t4_pendb", 8'(pend_b), 8'd1);
    cyc(0, 0, 0, 0);
    chk("t4_release", 8'(phase), 8'd1);

    // Test 5: asynchronous reset in the middle of A yellow.
    cyc(1, 0, 0, 0);
    chk("t5_penda_pre", 8'(pend_a), 8'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t5_tl1", 8'(TL1), 8'd1);
    chk("t5_tl3", 8'(TL3), 8'd1);
    chk("t5_tl2", 8'(TL2), 8'd0);
    chk("t5_phase", 8'(phase), 8'd0);
    chk("t5_penda", 8'(pend_a), 8'd0);
    chk("t5_pendb", 8'(pend_b), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    run_test1();

    // Test 2: max-out with det_a held.
    goto_phase0(1'b1);
    cnt = 1;
    for (int i = 0; i < 40 && phase === 3'd0; i++) begin
      cyc(1, (i == 0), 0, 0);
      if (phase === 3'd0) cnt++;
    end
    chk("t2_maxout", 8'(cnt), 8'(MAX_GREEN));
    for (int i = 0; i < YELLOW_T + ALLRED_T; i++) cyc(0, 0, 0, 0);
    chk("t2_bgrn", 8'(phase), 8'd3);

    // Test 3: resting A green with no demand, then immediate gap-out once B is requested.
    goto_phase0(1'b1);
    for (int i = 0; i < 100; i++) begin
      cyc(0, 0, 0, 0);
      chk("t3_rest", 8'(phase), 8'd0);
      chk("t3_tl1", 8'(TL1), 8'd1);
    end
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("t3_gapout", 8'(phase), 8'd1);

    // Randomized traffic with occasional preemption bursts.
    burst = 0; er = 0; ed = 0;
    for (int i = 0; i < 1500; i++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 39) == 0) begin
        burst = $urandom_range(1, 25);
        ed = 1'($urandom_range(0, 1));
      end
      er = (burst > 0);
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0), er,
          er ? ed : 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
